// File: rtl/raybox_zero_pkg.sv
// rtl/raybox_zero_pkg.sv - shared types and constants for the on-chip register SPI path
package raybox_zero_pkg;

    localparam int RBZ_CMD_W  = 4;
    localparam int RBZ_DATA_W = 24;
    localparam int RBZ_LEN_W  = 5;
    localparam int RBZ_DIV_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } spi_state_e;

    // Register opcodes written by the frame animator
    localparam logic [3:0] OP_SKY_COLOR   = 4'h0;
    localparam logic [3:0] OP_FLOOR_COLOR = 4'h1;
    localparam logic [3:0] OP_LEAK        = 4'h2;
    localparam logic [3:0] OP_VSHIFT      = 4'h4;

    function automatic int unsigned frame_bits(input int unsigned cmd_w,
                                               input int unsigned data_w,
                                               input int unsigned len);
        return cmd_w + ((len > data_w) ? data_w : len);
    endfunction

endpackage

// File: rtl/reg_spi_sequencer_if.sv
// rtl/reg_spi_sequencer_if.sv - requester A/B command handshake bundle
interface reg_spi_sequencer_if
    import raybox_zero_pkg::*;
#(
    parameter int CMD_W  = RBZ_CMD_W,
    parameter int DATA_W = RBZ_DATA_W,
    parameter int LEN_W  = RBZ_LEN_W
);
    logic              i_a_valid;
    logic [CMD_W-1:0]  i_a_cmd;
    logic [LEN_W-1:0]  i_a_len;
    logic [DATA_W-1:0] i_a_data;
    logic              o_a_ready;
    logic              i_b_valid;
    logic [CMD_W-1:0]  i_b_cmd;
    logic [LEN_W-1:0]  i_b_len;
    logic [DATA_W-1:0] i_b_data;
    logic              o_b_ready;

    modport master (
        output i_a_valid, i_a_cmd, i_a_len, i_a_data,
        output i_b_valid, i_b_cmd, i_b_len, i_b_data,
        input  o_a_ready, o_b_ready
    );

    modport slave (
        input  i_a_valid, i_a_cmd, i_a_len, i_a_data,
        input  i_b_valid, i_b_cmd, i_b_len, i_b_data,
        output o_a_ready, o_b_ready
    );
endinterface

// File: rtl/spi_frame_tx.sv
// rtl/spi_frame_tx.sv - serialises one opcode+payload frame, mode 0, MSB first
module spi_frame_tx
    import raybox_zero_pkg::*;
#(
    parameter int CMD_W  = RBZ_CMD_W,
    parameter int DATA_W = RBZ_DATA_W,
    parameter int LEN_W  = RBZ_LEN_W,
    parameter int DIV_W  = RBZ_DIV_W
)(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [CMD_W-1:0]  i_cmd,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [DATA_W-1:0] i_data,
    input  logic [DIV_W-1:0]  i_div,
    output logic              o_csb,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic              o_busy,
    output logic              o_done
);
    localparam int FRAME_W = CMD_W + DATA_W;
    localparam int BCNT_W  = $clog2(FRAME_W + 1);

    spi_state_e         state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   hcnt_q, hcnt_d;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
    logic [FRAME_W-1:0] sh_q, sh_d;
    logic               done_q, done_d;
    logic [31:0]        len_c;
    logic [DATA_W-1:0]  data_al;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            hcnt_q  <= '0;
            bcnt_q  <= '0;
            sh_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            hcnt_q  <= hcnt_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            done_q  <= done_d;
        end
    end

    // Payload is left-justified under the opcode so the frame always leaves from the MSB
    always_comb begin
        len_c   = (32'(i_len) > 32'(DATA_W)) ? 32'(DATA_W) : 32'(i_len);
        data_al = i_data << (32'(DATA_W) - len_c);
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        hcnt_d  = hcnt_q;
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        done_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (i_start) begin
                state_d = ST_SETUP;
                div_d   = i_div;
                hcnt_d  = i_div;
                bcnt_d  = BCNT_W'(frame_bits(CMD_W, DATA_W, 32'(i_len)));
                sh_d    = {i_cmd, data_al};
            end
        end else if (hcnt_q != '0) begin
            hcnt_d = hcnt_q - DIV_W'(1);
        end else begin
            hcnt_d = div_q;
            case (state_q)
                ST_SETUP: state_d = ST_HI;
                ST_HI: begin
                    if (bcnt_q == BCNT_W'(1)) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_LO;
                        bcnt_d  = bcnt_q - BCNT_W'(1);
                        sh_d    = sh_q << 1;
                    end
                end
                ST_LO:   state_d = ST_HI;
                ST_HOLD: state_d = ST_GAP;
                ST_GAP: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign o_csb  = (state_q == ST_IDLE) || (state_q == ST_GAP);
    assign o_sclk = (state_q == ST_HI);
    assign o_mosi = sh_q[FRAME_W-1];
    assign o_busy = (state_q != ST_IDLE);
    assign o_done = done_q;

endmodule

// File: rtl/reg_spi_sequencer.sv
// rtl/reg_spi_sequencer.sv - arbitrates host and animator requests onto the rbzero register SPI
module reg_spi_sequencer
    import raybox_zero_pkg::*;
#(
    parameter int CMD_W  = RBZ_CMD_W,
    parameter int DATA_W = RBZ_DATA_W,
    parameter int LEN_W  = RBZ_LEN_W,
    parameter int DIV_W  = RBZ_DIV_W
)(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [DIV_W-1:0]   i_div,
    input  logic               i_vblank,
    input  logic               i_b_vblank_only,
    reg_spi_sequencer_if.slave req,
    output logic               o_csb,
    output logic               o_sclk,
    output logic               o_mosi,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_done_src
);
    logic              b_elig, grant_a, grant_b;
    logic              rr_b_q, rr_b_d;
    logic              src_q, src_d;
    logic              tx_busy, tx_done;
    logic [CMD_W-1:0]  cmd_sel;
    logic [LEN_W-1:0]  len_sel;
    logic [DATA_W-1:0] data_sel;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rr_b_q <= 1'b0;
            src_q  <= 1'b0;
        end else begin
            rr_b_q <= rr_b_d;
            src_q  <= src_d;
        end
    end

    // rr_b_q set means B wins the next tie; an ineligible B never holds A off
    always_comb begin
        b_elig  = req.i_b_valid & (~i_b_vblank_only | i_vblank);
        grant_a = ~i_reset & ~tx_busy & req.i_a_valid & (~b_elig | ~rr_b_q);
        grant_b = ~i_reset & ~tx_busy & b_elig & (~req.i_a_valid | rr_b_q);
        rr_b_d  = rr_b_q;
        src_d   = src_q;
        if (grant_a) begin
            rr_b_d = 1'b1;
            src_d  = 1'b0;
        end else if (grant_b) begin
            rr_b_d = 1'b0;
            src_d  = 1'b1;
        end
        cmd_sel  = grant_b ? req.i_b_cmd  : req.i_a_cmd;
        len_sel  = grant_b ? req.i_b_len  : req.i_a_len;
        data_sel = grant_b ? req.i_b_data : req.i_a_data;
    end

    assign req.o_a_ready = grant_a;
    assign req.o_b_ready = grant_b;

    spi_frame_tx #(
        .CMD_W  (CMD_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W),
        .DIV_W  (DIV_W)
    ) u_tx (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (grant_a | grant_b),
        .i_cmd   (cmd_sel),
        .i_len   (len_sel),
        .i_data  (data_sel),
        .i_div   (i_div),
        .o_csb   (o_csb),
        .o_sclk  (o_sclk),
        .o_mosi  (o_mosi),
        .o_busy  (tx_busy),
        .o_done  (tx_done)
    );

    assign o_busy     = tx_busy;
    assign o_done     = tx_done;
    assign o_done_src = tx_done & src_q;

endmodule

// File: doc/reg_spi_sequencer.md
Name: reg_spi_sequencer

Overview:
- On-chip SPI controller that drives the rbzero general-register SPI peripheral (i_reg_csb/i_reg_sclk/i_reg_mosi) from two internal requesters.
- Requester A is the host/config path; requester B is the frame-synchronous animator, optionally gated to vertical blanking.
- The block arbitrates between A and B, serialises one command frame (opcode plus variable-length payload, MSB first) and reports completion.
- It sits beside rbzero inside top_raybox_zero_fsm. Its SPI outputs replace the raw pad inputs when on-chip control is selected.

Parameters:
- CMD_W, 4, opcode width in bits.
- DATA_W, 24, maximum payload width in bits.
- LEN_W, 5, width of the payload-length field.
- DIV_W, 4, width of the SCLK half-period divider.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_div  in  DIV_W  SCLK half-period: H = i_div+1 clocks.
- i_vblank  in  1  vertical blank from rbzero.
- i_b_vblank_only  in  1  when 1, B may only be granted while i_vblank=1.
- i_a_valid  in  1  A request valid.
- i_a_cmd  in  CMD_W  A opcode.
- i_a_len  in  LEN_W  A payload bit count.
- i_a_data  in  DATA_W  A payload, right-justified.
- o_a_ready  out  1  A accepted this cycle.
- i_b_valid, i_b_cmd, i_b_len, i_b_data, o_b_ready: same meanings for B.
- o_csb  out  1  SPI chip select, active low.
- o_sclk  out  1  SPI clock, idles low (mode 0).
- o_mosi  out  1  SPI data.
- o_busy  out  1  high from the cycle after accept until back in IDLE.
- o_done  out  1  one-cycle pulse when a frame completes.
- o_done_src  out  1  source of the completed frame (0=A, 1=B); valid with o_done.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - o_csb=1, o_sclk=0, o_mosi=0; o_busy=0, o_done=0, o_done_src=0; both readys=0.
  - State=IDLE, round-robin pointer favours A. Any in-flight frame is abandoned and not reported.
- Handshake:
  - A transfer occurs when valid&ready in the same cycle.
  - readys are driven only in IDLE. At most one ready is high per cycle.
  - A requester must hold cmd/len/data stable while valid is high and not yet accepted.
- Arbitration (IDLE only):
  - B is eligible when i_b_valid & (~i_b_vblank_only | i_vblank).
  - Only A valid: grant A. Only B eligible: grant B.
  - Both: grant the one not granted last. After reset, A wins the first tie.
  - An ineligible B never blocks A.
- On accept, the following are latched: cmd, data, source, H, and N = CMD_W + min(len, DATA_W).
  - len=0 sends the opcode only. len>DATA_W is clamped to DATA_W.
  - i_div changes mid-frame have no effect.
- Bit order: cmd MSB..LSB, then data[len-1]..data[0].
- FSM, each state lasting H clocks unless noted:
  - IDLE: csb=1, sclk=0.
  - SETUP: csb=0, mosi=bit0.
  - HI: sclk=1; the peripheral samples on the rising edge.
  - LO: sclk=0, mosi=next bit. HI and LO alternate until HI of the last bit.
  - HOLD: sclk=0, csb=0.
  - GAP: csb=1.
  - Then return to IDLE.
- Timing for accept at cycle T:
  - csb is low for cycles T+1..T+(2N+1)H.
  - GAP spans the next H cycles.
  - IDLE is entered and o_done pulses at cycle T+1+(2N+2)H.
  - Exactly N rising SCLK edges per frame.
- Back-to-back: a new request may be accepted on the same cycle o_done pulses. The minimum csb-high gap between frames is therefore H+1 clocks.
- o_mosi holds its last value in HOLD/GAP/IDLE and returns to 0 only on reset.
- Counter widths: the half-period counter is DIV_W bits. The bit counter is wide enough for CMD_W+DATA_W (≥5 bits at defaults).

Decomposition:
- Shared package raybox_zero_pkg holds:
  - state encoding localparams (IDLE, SETUP, HI, LO, HOLD, GAP);
  - CMD_W/DATA_W defaults;
  - register opcode constants used by requester B.
- One natural sub-module: spi_frame_tx, containing the FSM, divider, bit counter and shift register, with a single start/cmd/len/data interface plus done.
- Arbitration and ready generation stay in reg_spi_sequencer.

Test Plan:
- Single A frame: div=0, A cmd=4'hA len=8 data=24'h5C, accepted at T. Required response:
  - MOSI sampled on rising edges reads 1010_01011100;
  - csb low T+1..T+25;
  - o_done=1, o_done_src=0 at T+27.
- Divider: div=3 (H=4), cmd=4'h3 len=0. Required response:
  - 4 SCLK rises, each high 4 clocks;
  - csb low 36 clocks;
  - done 41 clocks after accept.
- Round-robin: A and B both valid continuously, vblank_only=0. Required response:
  - grants alternate A,B,A,B;
  - o_done_src follows 0,1,0,1.
- Vblank gating: vblank_only=1, B valid, vblank=0 for 100 clocks. Required response:
  - o_b_ready stays 0; an A request issued meanwhile is served;
  - B is accepted within 1 clock of vblank rising (when idle).
- Clamp and stability: len=31, and i_div changed mid-frame. Required response:
  - exactly 28 SCLK rises;
  - the original H is kept throughout the frame.
- Reset mid-frame: assert i_reset during HI of bit 5. Required response:
  - same cycle: csb=1, sclk=0, mosi=0, busy=0;
  - no o_done;
  - after release, a tie grants A first.
